// File: rtl/serv_wb_arbiter.sv
// serv_wb_arbiter: shares one Wishbone master port between the SERV
// instruction bus (ibus, read-only fetch) and data bus (dbus).
//
// Ports
//   i_clk, i_rst_n          clock, synchronous active-low reset
//   i_ibus_*  / o_ibus_*    fetch master: adr, cyc in; rdt, ack, err out
//   i_dbus_*  / o_dbus_*    data master: adr, dat, sel, we, cyc in; rdt, ack, err out
//   o_wb_* / i_wb_*         shared Wishbone port towards the slave
//   o_busy                  a grant is currently held
//
// Arbitration is round-robin on ties, with a one-cycle IDLE gap after every
// transaction. Read data and acks are steered combinationally.
//
// Optional feature: define SERV_WB_ARBITER_WATCHDOG_EN to add an 8-bit
// watchdog that terminates a grant with o_<m>_err after TIMEOUT cycles
// without ack. Without the macro o_ibus_err/o_dbus_err are tied low.
module serv_wb_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  // instruction bus
  input  logic [31:0] i_ibus_adr,
  input  logic        i_ibus_cyc,
  output logic [31:0] o_ibus_rdt,
  output logic        o_ibus_ack,
  output logic        o_ibus_err,
  // data bus
  input  logic [31:0] i_dbus_adr,
  input  logic [31:0] i_dbus_dat,
  input  logic [3:0]  i_dbus_sel,
  input  logic        i_dbus_we,
  input  logic        i_dbus_cyc,
  output logic [31:0] o_dbus_rdt,
  output logic        o_dbus_ack,
  output logic        o_dbus_err,
  // shared wishbone
  output logic [31:0] o_wb_adr,
  output logic [31:0] o_wb_dat,
  output logic [3:0]  o_wb_sel,
  output logic        o_wb_we,
  output logic        o_wb_cyc,
  input  logic [31:0] i_wb_rdt,
  input  logic        i_wb_ack,
  // status
  output logic        o_busy
);

  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IBUS = 2'd1,
    DBUS = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   last_dbus;       // 1: dbus held the most recent grant
  logic   last_dbus_nxt;
  logic   wd_hit;          // watchdog limit reached this cycle

`ifdef SERV_WB_ARBITER_WATCHDOG_EN
  logic [CNT_W-1:0] wd_cnt;
  logic [CNT_W-1:0] wd_cnt_nxt;

  assign wd_hit = (wd_cnt == CNT_W'(TIMEOUT));

  // Counter is held at 0 in IDLE so it starts from 0 on every grant.
  always_comb begin
    wd_cnt_nxt = wd_cnt;
    if (state == IDLE) begin
      wd_cnt_nxt = '0;
    end else if (!i_wb_ack) begin
      wd_cnt_nxt = CNT_W'(wd_cnt + CNT_W'(1));
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wd_cnt <= '0;
    end else begin
      wd_cnt <= wd_cnt_nxt;
    end
  end
`else
  logic unused_timeout;

  assign wd_hit         = 1'b0;
  assign unused_timeout = ^CNT_W'(TIMEOUT);
`endif

  // State and round-robin flag register.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state     <= IDLE;
      last_dbus <= 1'b0;
    end else begin
      state     <= state_nxt;
      last_dbus <= last_dbus_nxt;
    end
  end

  // Next-state logic; a grant ends on ack, on cyc drop, or on watchdog expiry.
  always_comb begin
    state_nxt     = state;
    last_dbus_nxt = last_dbus;
    case (state)
      IDLE: begin
        if (i_ibus_cyc && i_dbus_cyc) begin
          state_nxt = last_dbus ? IBUS : DBUS;
        end else if (i_ibus_cyc) begin
          state_nxt = IBUS;
        end else if (i_dbus_cyc) begin
          state_nxt = DBUS;
        end
      end
      IBUS: begin
        if (i_wb_ack || !i_ibus_cyc || wd_hit) begin
          state_nxt     = IDLE;
          last_dbus_nxt = 1'b0;
        end
      end
      DBUS: begin
        if (i_wb_ack || !i_dbus_cyc || wd_hit) begin
          state_nxt     = IDLE;
          last_dbus_nxt = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Shared bus mux; IDLE drives all request fields to zero.
  always_comb begin
    o_wb_adr = '0;
    o_wb_dat = '0;
    o_wb_sel = '0;
    o_wb_we  = 1'b0;
    o_wb_cyc = 1'b0;
    case (state)
      IBUS: begin
        o_wb_adr = i_ibus_adr;
        o_wb_sel = 4'hF;
        o_wb_cyc = i_ibus_cyc;
      end
      DBUS: begin
        o_wb_adr = i_dbus_adr;
        o_wb_dat = i_dbus_dat;
        o_wb_sel = i_dbus_sel;
        o_wb_we  = i_dbus_we;
        o_wb_cyc = i_dbus_cyc;
      end
      default: begin
      end
    endcase
  end

  assign o_ibus_rdt = i_wb_rdt;
  assign o_dbus_rdt = i_wb_rdt;

  // A real ack always wins over a simultaneous watchdog expiry.
  assign o_ibus_ack = i_wb_ack && (state == IBUS);
  assign o_dbus_ack = i_wb_ack && (state == DBUS);
  assign o_ibus_err = wd_hit && !i_wb_ack && (state == IBUS);
  assign o_dbus_err = wd_hit && !i_wb_ack && (state == DBUS);

  assign o_busy = (state != IDLE);

endmodule

// File: tb/tb_serv_wb_arbiter.sv
module tb_serv_wb_arbiter;

`ifdef SERV_WB_ARBITER_WATCHDOG_EN
  localparam int unsigned TO = 4;
  localparam bit          WD = 1'b1;
`else
  localparam int unsigned TO = 255;
  localparam bit          WD = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic [31:0] ibus_adr;
  logic        ibus_cyc;
  logic [31:0] ibus_rdt;
  logic        ibus_ack;
  logic        ibus_err;
  logic [31:0] dbus_adr;
  logic [31:0] dbus_dat;
  logic [3:0]  dbus_sel;
  logic        dbus_we;
  logic        dbus_cyc;
  logic [31:0] dbus_rdt;
  logic        dbus_ack;
  logic        dbus_err;
  logic [31:0] wb_adr;
  logic [31:0] wb_dat;
  logic [3:0]  wb_sel;
  logic        wb_we;
  logic        wb_cyc;
  logic [31:0] wb_rdt;
  logic        wb_ack;
  logic        busy;

  int checks = 0;
  int errors = 0;

  serv_wb_arbiter #(.TIMEOUT(TO)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_ibus_adr (ibus_adr),
    .i_ibus_cyc (ibus_cyc),
    .o_ibus_rdt (ibus_rdt),
    .o_ibus_ack (ibus_ack),
    .o_ibus_err (ibus_err),
    .i_dbus_adr (dbus_adr),
    .i_dbus_dat (dbus_dat),
    .i_dbus_sel (dbus_sel),
    .i_dbus_we  (dbus_we),
    .i_dbus_cyc (dbus_cyc),
    .o_dbus_rdt (dbus_rdt),
    .o_dbus_ack (dbus_ack),
    .o_dbus_err (dbus_err),
    .o_wb_adr   (wb_adr),
    .o_wb_dat   (wb_dat),
    .o_wb_sel   (wb_sel),
    .o_wb_we    (wb_we),
    .o_wb_cyc   (wb_cyc),
    .i_wb_rdt   (wb_rdt),
    .i_wb_ack   (wb_ack),
    .o_busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one clock and move just past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic icyc;
    logic dcyc;
    logic ack;
    logic e_cyc;
    logic e_iack;
    logic e_dack;
    logic e_busy;
  } vec_t;

  vec_t vecs[20];

  // Reference model: who owns the bus, who owned it last, and how long.
  int m_owner;   // 0 none, 1 ibus, 2 dbus
  int m_last;    // 1 ibus, 2 dbus
  int m_cnt;

  task automatic model_reset();
    m_owner = 0;
    m_last  = 1;
    m_cnt   = 0;
  endtask

  task automatic model_step();
    bit own_cyc;
    if (m_owner == 0) begin
      if (ibus_cyc && dbus_cyc) m_owner = (m_last == 1) ? 2 : 1;
      else if (ibus_cyc)        m_owner = 1;
      else if (dbus_cyc)        m_owner = 2;
      m_cnt = 0;
    end else begin
      own_cyc = (m_owner == 1) ? ibus_cyc : dbus_cyc;
      if (wb_ack || !own_cyc || (WD && m_cnt == int'(TO))) begin
        m_last  = m_owner;
        m_owner = 0;
      end else begin
        m_cnt++;
      end
    end
  endtask

  task automatic model_check();
    logic [31:0] e_adr, e_dat;
    logic [3:0]  e_sel;
    logic        e_we, e_cyc, e_err;
    e_adr = 0; e_dat = 0; e_sel = 0; e_we = 0; e_cyc = 0;
    if (m_owner == 1) begin
      e_adr = ibus_adr; e_sel = 4'hF; e_cyc = ibus_cyc;
    end else if (m_owner == 2) begin
      e_adr = dbus_adr; e_dat = dbus_dat; e_sel = dbus_sel; e_we = dbus_we; e_cyc = dbus_cyc;
    end
    e_err = WD && (m_owner != 0) && (m_cnt == int'(TO)) && !wb_ack;
    chk("rnd_adr", wb_adr, e_adr);
    chk("rnd_dat", wb_dat, e_dat);
    chk("rnd_sel", 32'(wb_sel), 32'(e_sel));
    chk("rnd_we", 32'(wb_we), 32'(e_we));
    chk("rnd_cyc", 32'(wb_cyc), 32'(e_cyc));
    chk("rnd_iack", 32'(ibus_ack), 32'(wb_ack && m_owner == 1));
    chk("rnd_dack", 32'(dbus_ack), 32'(wb_ack && m_owner == 2));
    chk("rnd_ierr", 32'(ibus_err), 32'(e_err && m_owner == 1));
    chk("rnd_derr", 32'(dbus_err), 32'(e_err && m_owner == 2));
    chk("rnd_busy", 32'(busy), 32'(m_owner != 0));
    chk("rnd_irdt", ibus_rdt, wb_rdt);
    chk("rnd_drdt", dbus_rdt, wb_rdt);
  endtask

  initial begin
    rst_n = 1'b0;
    ibus_adr = 0; ibus_cyc = 0;
    dbus_adr = 0; dbus_dat = 0; dbus_sel = 0; dbus_we = 0; dbus_cyc = 0;
    wb_rdt = 0; wb_ack = 0;

    // Reset: requests and ack present while in reset produce nothing.
    tick(); tick();
    ibus_cyc = 1; dbus_cyc = 1; wb_ack = 1;
    tick();
    chk("rst_cyc", 32'(wb_cyc), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_acks", 32'({ibus_ack, dbus_ack}), 0);
    chk("rst_errs", 32'({ibus_err, dbus_err}), 0);
    ibus_cyc = 0; dbus_cyc = 0; wb_ack = 0;
    rst_n = 1'b1;

    // Cycle table: ties, round-robin, stray acks, abort, waiting master.
    //          icyc dcyc ack  cyc iack dack busy
    vecs[0]  = '{1, 1, 0,  0, 0, 0, 0};
    vecs[1]  = '{1, 1, 0,  1, 0, 0, 1};
    vecs[2]  = '{1, 1, 1,  1, 0, 1, 1};
    vecs[3]  = '{1, 1, 0,  0, 0, 0, 0};
    vecs[4]  = '{1, 1, 0,  1, 0, 0, 1};
    vecs[5]  = '{1, 1, 1,  1, 1, 0, 1};
    vecs[6]  = '{1, 1, 0,  0, 0, 0, 0};
    vecs[7]  = '{1, 1, 0,  1, 0, 0, 1};
    vecs[8]  = '{0, 1, 1,  1, 0, 1, 1};
    vecs[9]  = '{0, 0, 1,  0, 0, 0, 0};
    vecs[10] = '{1, 0, 0,  0, 0, 0, 0};
    vecs[11] = '{1, 0, 0,  1, 0, 0, 1};
    vecs[12] = '{0, 0, 0,  0, 0, 0, 1};
    vecs[13] = '{0, 0, 1,  0, 0, 0, 0};
    vecs[14] = '{0, 1, 0,  0, 0, 0, 0};
    vecs[15] = '{1, 1, 0,  1, 0, 0, 1};
    vecs[16] = '{1, 1, 1,  1, 0, 1, 1};
    vecs[17] = '{1, 0, 0,  0, 0, 0, 0};
    vecs[18] = '{1, 0, 1,  1, 1, 0, 1};
    vecs[19] = '{0, 0, 0,  0, 0, 0, 0};
    for (int i = 0; i < 20; i++) begin
      ibus_cyc = vecs[i].icyc;
      dbus_cyc = vecs[i].dcyc;
      wb_ack   = vecs[i].ack;
      #1;
      chk($sformatf("vec%0d_cyc", i), 32'(wb_cyc), 32'(vecs[i].e_cyc));
      chk($sformatf("vec%0d_iack", i), 32'(ibus_ack), 32'(vecs[i].e_iack));
      chk($sformatf("vec%0d_dack", i), 32'(dbus_ack), 32'(vecs[i].e_dack));
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].e_busy));
      chk($sformatf("vec%0d_err", i), 32'({ibus_err, dbus_err}), 0);
      tick();
    end
    ibus_cyc = 0; dbus_cyc = 0; wb_ack = 0;

    // Single fetch; dbus payload held non-zero to prove it is not muxed in.
    dbus_dat = 32'hFFFF_FFFF; dbus_we = 1; dbus_sel = 4'h0; dbus_adr = 32'h1234;
    tick();
    ibus_cyc = 1; ibus_adr = 32'h100;
    #1;
    chk("fetch_req_cyc", 32'(wb_cyc), 0);
    tick();
    chk("fetch_cyc", 32'(wb_cyc), 1);
    chk("fetch_adr", wb_adr, 32'h100);
    chk("fetch_sel", 32'(wb_sel), 32'hF);
    chk("fetch_we", 32'(wb_we), 0);
    chk("fetch_dat", wb_dat, 0);
    tick(); tick();
    wb_rdt = 32'hDEAD_BEEF; wb_ack = 1;
    #1;
    chk("fetch_iack", 32'(ibus_ack), 1);
    chk("fetch_rdt", ibus_rdt, 32'hDEAD_BEEF);
    chk("fetch_dack", 32'(dbus_ack), 0);
    tick();
    wb_ack = 0; ibus_cyc = 0;
    #1;
    chk("fetch_idle", 32'(busy), 0);

    // Store mirrors dbus fields exactly.
    tick();
    dbus_cyc = 1; dbus_adr = 32'h2004; dbus_dat = 32'h55AA; dbus_sel = 4'h3; dbus_we = 1;
    #1;
    chk("store_idle_adr", wb_adr, 0);
    tick();
    chk("store_adr", wb_adr, 32'h2004);
    chk("store_dat", wb_dat, 32'h55AA);
    chk("store_sel", 32'(wb_sel), 32'h3);
    chk("store_we", 32'(wb_we), 1);
    chk("store_cyc", 32'(wb_cyc), 1);
    tick();
    wb_ack = 1;
    #1;
    chk("store_dack", 32'(dbus_ack), 1);
    chk("store_iack", 32'(ibus_ack), 0);
    tick();
    wb_ack = 0; dbus_cyc = 0;

    // Reset in the middle of a dbus grant abandons it.
    tick();
    dbus_cyc = 1;
    tick();
    chk("mrst_busy_pre", 32'(busy), 1);
    rst_n = 0;
    tick();
    chk("mrst_cyc", 32'(wb_cyc), 0);
    chk("mrst_busy", 32'(busy), 0);
    rst_n = 1; dbus_cyc = 0; wb_ack = 1;
    #1;
    chk("mrst_late_ack", 32'(dbus_ack), 0);
    tick();
    chk("mrst_late_ack2", 32'({ibus_ack, dbus_ack}), 0);
    wb_ack = 0;

`ifdef SERV_WB_ARBITER_WATCHDOG_EN
    // Watchdog expiry with no ack.
    tick();
    dbus_cyc = 1;
    for (int k = 0; k <= 4; k++) begin
      tick();
      if (k < 4) begin
        chk($sformatf("wd_wait%0d_err", k), 32'(dbus_err), 0);
        chk($sformatf("wd_wait%0d_busy", k), 32'(busy), 1);
      end else begin
        chk("wd_err", 32'(dbus_err), 1);
        chk("wd_err_noack", 32'(dbus_ack), 0);
        chk("wd_err_ierr", 32'(ibus_err), 0);
      end
    end
    dbus_cyc = 0;
    tick();
    chk("wd_after_busy", 32'(busy), 0);
    chk("wd_after_err", 32'(dbus_err), 0);
    // Ack on the limit cycle wins over the watchdog.
    dbus_cyc = 1;
    for (int k = 0; k <= 4; k++) begin
      tick();
      if (k == 4) begin
        wb_ack = 1;
        #1;
        chk("wd_lim_ack", 32'(dbus_ack), 1);
        chk("wd_lim_err", 32'(dbus_err), 0);
      end
    end
    tick();
    wb_ack = 0; dbus_cyc = 0;
    #1;
    chk("wd_lim_idle", 32'(busy), 0);
`else
    // Without the watchdog a grant waits indefinitely.
    tick();
    dbus_cyc = 1;
    tick();
    for (int k = 0; k < 20; k++) begin
      tick();
      chk($sformatf("nowd%0d_busy", k), 32'(busy), 1);
      chk($sformatf("nowd%0d_err", k), 32'({ibus_err, dbus_err}), 0);
    end
    dbus_cyc = 0;
    tick();
`endif

    // Randomized traffic against the reference model.
    ibus_cyc = 0; dbus_cyc = 0; wb_ack = 0;
    rst_n = 0;
    tick();
    rst_n = 1;
    model_reset();
    for (int i = 0; i < 3000; i++) begin
      tick();
      model_step();
      ibus_cyc = ($urandom % 8) != 0;
      dbus_cyc = ($urandom % 8) != 0;
      wb_ack   = ($urandom % 4) == 0;
      ibus_adr = $urandom;
      dbus_adr = $urandom;
      dbus_dat = $urandom;
      dbus_sel = 4'($urandom);
      dbus_we  = 1'($urandom);
      wb_rdt   = $urandom;
      #1;
      model_check();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
